register_file_v2: RTL and testbench
===================================

Name: register_file_v2

Overview:
Parametrised successor to the 32x64 RISC-V integer register file used by the datapath. It has:
- configurable data width and register count;
- x0 hardwired to zero;
- two combinational read ports;
- one write port on the clock's positive edge;
- a sequenced bulk-clear engine that zeroes the array one entry per cycle.

An optional write-to-read bypass lets the decode stage read a value in the same cycle it is written back.

Parameters:
XLEN, 64, data width in bits of every register and data port
NREG, 32, number of architectural registers; power of two, minimum 4
AW, $clog2(NREG), register index width (derived; not to be overridden)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset)
rs1  input  AW  read port 1 index
rs2  input  AW  read port 2 index
rd  input  AW  write index
RegWrite  input  1  write enable, sampled at posedge clk
WriteData  input  XLEN  write data
ReadData1  output  XLEN  contents of register rs1
ReadData2  output  XLEN  contents of register rs2
clear_req  input  1  request to zero the whole array, sampled at posedge clk
clear_busy  output  1  high while the clear sequence runs
clear_done  output  1  one-cycle pulse on the final clear cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - all NREG entries forced to 0; FSM forced to IDLE; clear index forced to 1.
  - Outputs: clear_busy=0, clear_done=0, ReadData1=ReadData2=0.
  - Reset deassertion is synchronised by the user; the block is usable from the first posedge after reset=1.
- Reads: combinational, zero cycles of latency. ReadDataN = reg[rsN].
  - rsN==0 always returns 0, regardless of any prior write to index 0.
- Writes:
  - At posedge clk, if RegWrite=1 and rd!=0 and FSM==IDLE, then reg[rd] <= WriteData.
  - rd==0 writes are dropped silently; reg[0] never holds a nonzero value.
  - RegWrite must be stable before the posedge; a write is visible on the read ports (non-bypass) from the cycle after that edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR: at posedge with clear_req=1. clear_busy goes high from that edge.
  - CLEAR: each posedge zeroes reg[idx], then idx increments. Takes NREG-1 cycles, covering indices 1..NREG-1.
  - CLEAR -> IDLE: on the edge that clears index NREG-1. clear_done=1 during the cycle in which idx==NREG-1, and clear_busy falls after that edge. idx then resets to 1.
  - While in CLEAR:
    - RegWrite is ignored;
    - clear_req is ignored (no restart);
    - ReadData1 and ReadData2 both return 0, regardless of which entries have been cleared so far.
- Simultaneous events:
  - clear_req=1 together with RegWrite=1 in IDLE: the write commits on that edge, and the clear begins on the same edge. The written value is erased within the sequence.
  - Async reset during CLEAR: aborts immediately into the full reset state.
- Widths: indices are unsigned AW bits; no out-of-range indices are possible.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - If RegWrite=1, FSM==IDLE, rd!=0 and rd==rsN, then ReadDataN = WriteData combinationally in the same cycle (write-first).
  - Applies to both ports independently.
  - Never applies to index 0 or during CLEAR.
- Undefined: ReadDataN reflects the stored value only (read-first). The new value appears after the posedge.
- Storage and FSM behaviour are identical in both builds.

Test Plan:
- Reset then zero write, with reset=0 then 1: write rd=0, WriteData=64'd1, RegWrite=1 for one edge; rs1=0 -> ReadData1=0.
- Normal write and read: write rd=2, WriteData=64'hDEAD_BEEF at a posedge; next cycle rs1=2 -> 64'hDEAD_BEEF, and rs2=3 -> 0.
- Async reset mid-cycle: with reg[2]=64'hDEAD_BEEF, pull reset=0 between edges. ReadData1 (rs1=2) drops to 0 immediately, without waiting for clk; after release, still 0.
- Bypass: hold RegWrite=1, rd=rs1=rs2=5, WriteData=64'h1234.
  - With REGFILE_BYPASS_EN: both ports read 64'h1234 before the edge.
  - Without it: both read 0 before the edge and 64'h1234 after.
- Clear sequence with NREG=32: fill regs 1..31 with their index value, then pulse clear_req.
  - clear_busy is high for exactly 31 cycles, and clear_done pulses once.
  - A write to rd=7 mid-sequence is ignored, and reads return 0 throughout.
  - Afterwards every index reads 0, and a write to rd=4 of 64'h55 reads back 64'h55.
- Clear overlapping a write: clear_req=1 with RegWrite=1, rd=31, WriteData=64'hFF on the same edge -> after clear_done, rs1=31 reads 0.

Source files
------------

// File: rtl/register_file_v2.sv
// register_file_v2: XLEN x NREG register file with x0 tied to zero, two combinational
// read ports, one write port and a one-entry-per-cycle bulk-clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_v2 #(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic            RegWrite,
    input  logic [XLEN-1:0] WriteData,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    input  logic            clear_req,
    output logic            clear_busy,
    output logic            clear_done
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] regs [NREG];
    logic            wen;
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;

    assign wen = RegWrite && (rd != '0) && (state == IDLE);

    // clear_done is registered one cycle early so it is high exactly while idx == NREG-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= AW'(1);
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx == AW'(NREG - 1)) begin
                        state      <= IDLE;
                        idx        <= AW'(1);
                        clear_busy <= 1'b0;
                        clear_done <= 1'b0;
                    end else begin
                        idx        <= idx + AW'(1);
                        clear_done <= (idx == AW'(NREG - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[idx] <= '0;
        end else if (wen) begin
            regs[rd] <= WriteData;
        end
    end

    // Reads are blanked for the whole clear so partially-cleared contents never leak out
    assign stored1 = ((state == CLEAR) || (rs1 == '0)) ? '0 : regs[rs1];
    assign stored2 = ((state == CLEAR) || (rs2 == '0)) ? '0 : regs[rs2];

`ifdef REGFILE_BYPASS_EN
    assign ReadData1 = (wen && (rd == rs1)) ? WriteData : stored1;
    assign ReadData2 = (wen && (rd == rs2)) ? WriteData : stored2;
`else
    assign ReadData1 = stored1;
    assign ReadData2 = stored2;
`endif

endmodule

// File: tb/tb_register_file_v2.sv
// Self-checking bench for register_file_v2: directed steps followed by random traffic,
// all checked against a behavioural array model of the register file.
module tb_register_file_v2;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      rs1, rs2, rd;
    logic            RegWrite;
    logic [XLEN-1:0] WriteData;
    logic [XLEN-1:0] ReadData1, ReadData2;
    logic            clear_req;
    logic            clear_busy, clear_done;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] mem [NREG];
    bit              clearing;
    int              remaining;

    register_file_v2 #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .RegWrite  (RegWrite),
        .WriteData (WriteData),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] expRead(input logic [4:0] rs);
        if (clearing || rs == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && rd != 5'd0 && rd == rs) return WriteData;
`endif
        return mem[rs];
    endfunction

    task automatic compare(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, " rd1"}, ReadData1, expRead(rs1));
        compare({tag, " rd2"}, ReadData2, expRead(rs2));
        compare({tag, " busy"}, {63'd0, clear_busy}, {63'd0, clearing});
        compare({tag, " done"}, {63'd0, clear_done}, {63'd0, (clearing && remaining == 1)});
    endtask

    task automatic modelReset();
        foreach (mem[i]) mem[i] = '0;
        clearing  = 1'b0;
        remaining = 0;
    endtask

    // Model advances one clock: either one step of the clear or an ordinary write/start
    task automatic modelEdge();
        if (clearing) begin
            remaining--;
            if (remaining == 0) begin
                clearing = 1'b0;
                foreach (mem[i]) mem[i] = '0;
            end
        end else begin
            if (RegWrite && rd != 5'd0) mem[rd] = WriteData;
            if (clear_req) begin
                clearing  = 1'b1;
                remaining = NREG - 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [XLEN-1:0] wd,
                                 input logic cr, input logic [4:0] a, input logic [4:0] b,
                                 input string tag);
        RegWrite  = we;
        rd        = wa;
        WriteData = wd;
        clear_req = cr;
        rs1       = a;
        rs2       = b;
        #1;
        checkOutput(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        int busyCount;
        int doneCount;

        modelReset();
        reset     = 1'b0;
        RegWrite  = 1'b0;
        rd        = 5'd0;
        WriteData = '0;
        clear_req = 1'b0;
        rs1       = 5'd2;
        rs2       = 5'd3;
        #11;
        checkOutput("reset_state");
        reset = 1'b1;
        #1;

        $display("[TB] zero-register write");
        applyStimulus(1'b1, 5'd0, 64'd1, 1'b0, 5'd0, 5'd0, "x0_write");
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, "x0_read");

        $display("[TB] normal write and read");
        applyStimulus(1'b1, 5'd2, 64'hDEAD_BEEF, 1'b0, 5'd2, 5'd3, "wr2");
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd2, 5'd3, "rd2");
        compare("rd2_const", ReadData1, 64'hDEAD_BEEF);

        $display("[TB] asynchronous reset between edges");
        rs1 = 5'd2;
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        compare("async_rst_rd1", ReadData1, 64'd0);
        checkOutput("async_rst");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("post_rst");

        $display("[TB] write/read same index");
        applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd5, 5'd5, "byp_pre");
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 5'd5, "byp_post");
        compare("byp_post_const", ReadData2, 64'h1234);

        $display("[TB] fill and clear");
        for (int i = 1; i < NREG; i++) begin
            applyStimulus(1'b1, 5'(i), 64'(i), 1'b0, 5'(i - 1), 5'(i), "fill");
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd31, "clr_start");
        busyCount = 0;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            if (clear_busy === 1'b1) busyCount++;
            if (clear_done === 1'b1) doneCount++;
            applyStimulus(i == 10, 5'd7, 64'd77, i == 5, 5'(i % NREG), 5'd7, "clr_run");
        end
        compare("clr_busy_cycles", 64'(busyCount), 64'd31);
        compare("clr_done_pulses", 64'(doneCount), 64'd1);
        for (int i = 0; i < NREG / 2; i++) begin
            applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'(2 * i), 5'(2 * i + 1), "clr_after");
        end
        applyStimulus(1'b1, 5'd4, 64'h55, 1'b0, 5'd4, 5'd7, "wr4");
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd4, 5'd7, "rd4");
        compare("rd4_const", ReadData1, 64'h55);

        $display("[TB] clear overlapping a write");
        applyStimulus(1'b1, 5'd31, 64'hFF, 1'b1, 5'd31, 5'd4, "ovl_start");
        for (int i = 0; i < 34; i++) begin
            applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 5'd4, "ovl_run");
        end
        compare("ovl_rd31", ReadData1, 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          {$urandom, $urandom}, $urandom_range(0, 29) == 0,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end
        checkOutput("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
